sysid_boot_checker: RTL and testbench



---
 rtl/sysid_chk_pkg.sv | 24 ++
 rtl/sysid_read_engine.sv | 80 ++++++++
 rtl/sysid_boot_checker.sv | 178 +++++++++++++++++
 tb/tb_sysid_boot_checker.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_chk_pkg.sv
// Shared types and constants for the sysid boot checker and its read engine.
package sysid_chk_pkg;

  localparam int   TO_W    = 16;
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    RST_WAIT,
    REQ_ID,
    WAIT_ID,
    REQ_TS,
    WAIT_TS,
    CHECK,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ENG_IDLE,
    ENG_REQ,
    ENG_WAIT
  } eng_state_t;

endpackage

// File: rtl/sysid_read_engine.sv
// Single-word Avalon-MM read with per-attempt timeout and bounded retry.
module sysid_read_engine
  import sysid_chk_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_go,
  input  logic        i_addr,
  output logic        o_avm_address,
  output logic        o_avm_read,
  input  logic        i_avm_waitrequest,
  input  logic        i_avm_readdatavalid,
  input  logic [31:0] i_avm_readdata,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_accept,
  output logic        o_retry,
  output logic        o_timeout
);

  localparam logic [TO_W-1:0] C_TERM      = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] C_MAX_RETRY = TO_W'(MAX_RETRIES);

  eng_state_t      r_state;
  eng_state_t      w_next;
  logic [TO_W-1:0] r_cnt;
  logic [TO_W-1:0] r_retry;
  logic            r_addr;
  logic            w_in_req;
  logic            w_active;
  logic            w_capture;
  logic            w_term;
  logic            w_can_retry;

  assign w_in_req    = (r_state == ENG_REQ);
  assign w_active    = (r_state != ENG_IDLE);
  // Data is only trusted in a WAIT cycle or in the cycle the request is accepted.
  assign w_capture   = i_avm_readdatavalid &&
                       ((w_in_req && !i_avm_waitrequest) || (r_state == ENG_WAIT));
  assign w_term      = w_active && !w_capture && (r_cnt == C_TERM);
  assign w_can_retry = (r_retry < C_MAX_RETRY);

  assign o_retry       = w_term && w_can_retry;
  assign o_timeout     = w_term && !w_can_retry;
  assign o_valid       = w_capture;
  assign o_accept      = w_in_req && !i_avm_waitrequest && !w_capture && !w_term;
  assign o_data        = i_avm_readdata;
  assign o_avm_read    = w_in_req;
  assign o_avm_address = r_addr;

  always_comb begin
    w_next = r_state;
    if (i_go)                        w_next = ENG_REQ;
    else if (w_capture || o_timeout) w_next = ENG_IDLE;
    else if (o_retry)                w_next = ENG_REQ;
    else if (o_accept)               w_next = ENG_WAIT;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ENG_IDLE;
      r_addr  <= 1'b0;
      r_cnt   <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_next;
      if (i_go) r_addr <= i_addr;

      if (i_go || o_retry) r_cnt <= '0;
      else if (w_active)   r_cnt <= r_cnt + 1'b1;

      if (i_go || w_capture) r_retry <= '0;
      else if (o_retry)      r_retry <= r_retry + 1'b1;
    end
  end

endmodule

// File: rtl/sysid_boot_checker.sv
// Reads the sysid ID and timestamp words after reset or start and flags mismatches.
// state    | meaning
// RST_WAIT | one cycle after reset, kicks off the ID read
// REQ_ID   | ID read request on the bus
// WAIT_ID  | ID read accepted, waiting for data
// REQ_TS   | timestamp read request on the bus
// WAIT_TS  | timestamp read accepted, waiting for data
// CHECK    | compare captured words against build-time values
// DONE     | status published, waiting for start
module sysid_boot_checker
  import sysid_chk_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1466022455,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout_err
);

  state_t      r_state;
  state_t      w_next;
  logic        w_go;
  logic        w_go_addr;
  logic        w_cap_id;
  logic        w_cap_ts;
  logic        w_check;
  logic        w_clr;
  logic        w_set_to;
  logic [31:0] w_e_data;
  logic        w_e_valid;
  logic        w_e_accept;
  logic        w_e_retry;
  logic        w_e_timeout;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;
  logic        r_pass;
  logic        r_id_mis;
  logic        r_ts_mis;
  logic        r_to_err;

  sysid_read_engine #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES)
  ) u_engine (
    .clock               (clock),
    .reset               (reset),
    .i_go                (w_go),
    .i_addr              (w_go_addr),
    .o_avm_address       (avm_address),
    .o_avm_read          (avm_read),
    .i_avm_waitrequest   (avm_waitrequest),
    .i_avm_readdatavalid (avm_readdatavalid),
    .i_avm_readdata      (avm_readdata),
    .o_data              (w_e_data),
    .o_valid             (w_e_valid),
    .o_accept            (w_e_accept),
    .o_retry             (w_e_retry),
    .o_timeout           (w_e_timeout)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= RST_WAIT;
    else       r_state <= w_next;
  end

  // The engine is launched one cycle ahead so its REQ phase lines up with REQ_x.
  always_comb begin
    w_next    = r_state;
    w_go      = 1'b0;
    w_go_addr = ADDR_ID;
    w_cap_id  = 1'b0;
    w_cap_ts  = 1'b0;
    w_check   = 1'b0;
    w_clr     = 1'b0;
    w_set_to  = 1'b0;
    case (r_state)
      RST_WAIT: begin
        w_go   = 1'b1;
        w_next = REQ_ID;
      end
      REQ_ID, WAIT_ID: begin
        if (w_e_valid) begin
          w_cap_id  = 1'b1;
          w_go      = 1'b1;
          w_go_addr = ADDR_TS;
          w_next    = REQ_TS;
        end else if (w_e_timeout) begin
          w_set_to = 1'b1;
          w_next   = DONE;
        end else if (w_e_accept) begin
          w_next = WAIT_ID;
        end else if (w_e_retry) begin
          w_next = REQ_ID;
        end
      end
      REQ_TS, WAIT_TS: begin
        if (w_e_valid) begin
          w_cap_ts = 1'b1;
          w_next   = CHECK;
        end else if (w_e_timeout) begin
          w_set_to = 1'b1;
          w_next   = DONE;
        end else if (w_e_accept) begin
          w_next = WAIT_TS;
        end else if (w_e_retry) begin
          w_next = REQ_TS;
        end
      end
      CHECK: begin
        w_check = 1'b1;
        w_next  = DONE;
      end
      DONE: begin
        if (start) begin
          w_clr  = 1'b1;
          w_go   = 1'b1;
          w_next = REQ_ID;
        end
      end
      default: w_next = RST_WAIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_id_value <= '0;
      r_ts_value <= '0;
      r_pass     <= 1'b0;
      r_id_mis   <= 1'b0;
      r_ts_mis   <= 1'b0;
      r_to_err   <= 1'b0;
    end else begin
      if (w_clr) begin
        r_pass   <= 1'b0;
        r_id_mis <= 1'b0;
        r_ts_mis <= 1'b0;
        r_to_err <= 1'b0;
      end
      if (w_cap_id) r_id_value <= w_e_data;
      if (w_cap_ts) r_ts_value <= w_e_data;
      if (w_set_to) begin
        r_to_err <= 1'b1;
        r_pass   <= 1'b0;
      end
      if (w_check) begin
        r_id_mis <= (r_id_value != EXPECTED_ID);
        r_ts_mis <= (r_ts_value != EXPECTED_TIMESTAMP);
        r_pass   <= (r_id_value == EXPECTED_ID) && (r_ts_value == EXPECTED_TIMESTAMP);
      end
    end
  end

  assign busy            = (r_state != DONE) && (r_state != RST_WAIT);
  assign done            = (r_state == DONE);
  assign pass            = r_pass;
  assign id_mismatch     = r_id_mis;
  assign ts_mismatch     = r_ts_mis;
  assign timeout_err     = r_to_err;
  assign id_value        = r_id_value;
  assign timestamp_value = r_ts_value;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: scripted sysid slave plus an outcome model per word.
module tb_sysid_boot_checker;

  localparam int          T      = 8;
  localparam int          R      = 2;
  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1466022455;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest   = 1'b0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] avm_readdata      = 32'h0;
  logic [31:0] id_value;
  logic [31:0] timestamp_value;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout_err;

  int total = 0;
  int bad   = 0;

  // slave configuration (bench-written) and slave state (slave-written)
  int          cfg_stall [2];
  int          cfg_lat   [2];
  int          fail_until[2];
  logic [31:0] cfg_data  [2];
  int          acc_tot   [2] = '{0, 0};
  int          addr_err  = 0;
  int          stall_left = 0;
  int          pend = 0;
  int          s_a  = 0;
  bit          stalling = 1'b0;
  bit          stale_inject = 1'b0;
  logic        stall_addr = 1'b0;
  logic [31:0] pend_data = 32'h0;

  logic [31:0] m_id = 32'h0;
  logic [31:0] m_ts = 32'h0;

  always #5 clock = ~clock;

  sysid_boot_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (T),
    .MAX_RETRIES        (R)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_readdata      (avm_readdata),
    .id_value          (id_value),
    .timestamp_value   (timestamp_value),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .id_mismatch       (id_mismatch),
    .ts_mismatch       (ts_mismatch),
    .timeout_err       (timeout_err)
  );

  // Slave: decides waitrequest/readdatavalid for the coming rising edge.
  always @(negedge clock) begin
    avm_readdatavalid = 1'b0;
    avm_waitrequest   = 1'b0;
    if (reset) begin
      stalling = 1'b0;
      pend     = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = pend_data;
        end
      end
      if (avm_read === 1'b1) begin
        s_a = int'(avm_address);
        if (stalling && avm_address !== stall_addr) addr_err++;
        if (!stalling) begin
          stalling   = 1'b1;
          stall_left = cfg_stall[s_a];
          stall_addr = avm_address;
        end
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          stalling = 1'b0;
          acc_tot[s_a]++;
          if (acc_tot[s_a] > fail_until[s_a]) begin
            if (cfg_lat[s_a] == 0) begin
              avm_readdatavalid = 1'b1;
              avm_readdata      = cfg_data[s_a];
            end else begin
              pend      = cfg_lat[s_a];
              pend_data = cfg_data[s_a];
            end
          end
        end
      end else begin
        stalling = 1'b0;
      end
    end
    if (stale_inject) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = 32'hDEAD_BEEF;
    end
  end

  // Reference model: number of accepted reads and whether the word is captured.
  function automatic int model_accepts(input int stall, input int fail_n);
    if (stall >= T) return 0;
    return (fail_n + 1 <= R + 1) ? fail_n + 1 : R + 1;
  endfunction

  function automatic bit model_ok(input int stall, input int lat, input int fail_n);
    return (stall < T) && (stall + lat <= T - 1) && (fail_n <= R);
  endfunction

  task automatic set_word(input int a, input int stall, input int lat, input int fail_n,
                          input logic [31:0] data);
    cfg_stall[a]  = stall;
    cfg_lat[a]    = lat;
    cfg_data[a]   = data;
    fail_until[a] = acc_tot[a] + fail_n;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < max && !ok) begin
      step(1);
      cyc++;
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    set_word(0, 0, 0, 0, EXP_ID);
    set_word(1, 0, 0, 0, EXP_TS);
    reset = 1'b1;
    step(3);
    total++; if (avm_read !== 1'b0) begin bad++; $display("FAIL rst_read got=%0b want=0", avm_read); end
    total++; if ({busy, done, pass} !== 3'b000) begin bad++; $display("FAIL rst_status got=%b want=000", {busy, done, pass}); end
    total++; if ({id_mismatch, ts_mismatch, timeout_err} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {id_mismatch, ts_mismatch, timeout_err}); end
    total++; if (id_value !== 32'h0 || timestamp_value !== 32'h0) begin bad++; $display("FAIL rst_values got=%h/%h want=0/0", id_value, timestamp_value); end
    reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || avm_read !== 1'b0) begin bad++; $display("FAIL rst_wait got busy=%0b read=%0b want 0/0", busy, avm_read); end
  endtask

  task automatic test_zero_wait;
    int a0, a1, cyc;
    bit ok;
    a0 = acc_tot[0];
    a1 = acc_tot[1];
    wait_done(40, cyc, ok);
    total++; if (!ok || cyc > 6) begin bad++; $display("FAIL zw_latency got=%0d cycles (done=%0b) want<=6", cyc, ok); end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL zw_pass got=%0b want=1", pass); end
    total++; if (timestamp_value !== EXP_TS) begin bad++; $display("FAIL zw_ts got=%h want=%h", timestamp_value, EXP_TS); end
    total++; if (id_value !== EXP_ID) begin bad++; $display("FAIL zw_id got=%h want=%h", id_value, EXP_ID); end
    total++; if (acc_tot[0] - a0 != 1 || acc_tot[1] - a1 != 1) begin bad++; $display("FAIL zw_accepts got=%0d/%0d want=1/1", acc_tot[0] - a0, acc_tot[1] - a1); end
    m_id = EXP_ID;
    m_ts = EXP_TS;
  endtask

  task automatic test_stall;
    int a0, a1, e0, cyc;
    bit ok;
    set_word(0, 4, 3, 0, EXP_ID);
    set_word(1, 4, 3, 0, EXP_TS);
    a0 = acc_tot[0];
    a1 = acc_tot[1];
    e0 = addr_err;
    pulse_start;
    wait_done(100, cyc, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_done got=0 want=1 within 100 cycles"); end
    total++; if (pass !== 1'b1 || timeout_err !== 1'b0) begin bad++; $display("FAIL stall_pass got pass=%0b to=%0b want 1/0", pass, timeout_err); end
    total++; if (acc_tot[0] - a0 != 1 || acc_tot[1] - a1 != 1) begin bad++; $display("FAIL stall_accepts got=%0d/%0d want=1/1", acc_tot[0] - a0, acc_tot[1] - a1); end
    total++; if (addr_err != e0) begin bad++; $display("FAIL stall_addr_stable got=%0d changes want=0", addr_err - e0); end
  endtask

  task automatic test_ts_mismatch;
    int cyc;
    bit ok;
    set_word(0, 1, 1, 0, EXP_ID);
    set_word(1, 1, 2, 0, 32'h1234_5678);
    pulse_start;
    wait_done(100, cyc, ok);
    total++; if (!ok) begin bad++; $display("FAIL tsm_done got=0 want=1"); end
    total++; if ({id_mismatch, ts_mismatch, pass} !== 3'b010) begin bad++; $display("FAIL tsm_flags got id/ts/pass=%b want=010", {id_mismatch, ts_mismatch, pass}); end
    total++; if (timestamp_value !== 32'h1234_5678) begin bad++; $display("FAIL tsm_value got=%h want=12345678", timestamp_value); end
    m_ts = 32'h1234_5678;
  endtask

  task automatic test_busy_start;
    int a0, a1, cyc;
    bit ok;
    set_word(0, 3, 2, 0, EXP_ID);
    set_word(1, 3, 2, 0, EXP_TS);
    a0 = acc_tot[0];
    a1 = acc_tot[1];
    pulse_start;
    total++; if ({done, busy, ts_mismatch, pass} !== 4'b0100) begin bad++; $display("FAIL bs_clear got done/busy/tsm/pass=%b want=0100", {done, busy, ts_mismatch, pass}); end
    step(2);
    pulse_start;
    wait_done(100, cyc, ok);
    total++; if (!ok || pass !== 1'b1) begin bad++; $display("FAIL bs_pass got done=%0b pass=%0b want 1/1", ok, pass); end
    total++; if (acc_tot[0] - a0 != 1 || acc_tot[1] - a1 != 1) begin bad++; $display("FAIL bs_accepts got=%0d/%0d want=1/1", acc_tot[0] - a0, acc_tot[1] - a1); end
    step(10);
    total++; if (done !== 1'b1 || acc_tot[0] - a0 != 1) begin bad++; $display("FAIL bs_hold got done=%0b id_accepts=%0d want 1/1", done, acc_tot[0] - a0); end
    m_id = EXP_ID;
    m_ts = EXP_TS;
  endtask

  task automatic test_timeout;
    int a0, a1, cyc;
    bit ok;
    set_word(0, 0, 1, 99, EXP_ID);
    set_word(1, 0, 0, 0, EXP_TS);
    a0 = acc_tot[0];
    a1 = acc_tot[1];
    pulse_start;
    wait_done(200, cyc, ok);
    total++; if (!ok || cyc < 23 || cyc > 26) begin bad++; $display("FAIL to_latency got=%0d (done=%0b) want 23..26", cyc, ok); end
    total++; if ({timeout_err, pass} !== 2'b10) begin bad++; $display("FAIL to_flags got to/pass=%b want=10", {timeout_err, pass}); end
    total++; if (acc_tot[0] - a0 != 3 || acc_tot[1] - a1 != 0) begin bad++; $display("FAIL to_accepts got=%0d/%0d want=3/0", acc_tot[0] - a0, acc_tot[1] - a1); end
    total++; if (id_value !== m_id || timestamp_value !== m_ts) begin bad++; $display("FAIL to_values got=%h/%h want=%h/%h", id_value, timestamp_value, m_id, m_ts); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit ok;
    set_word(0, 2, 1, 0, EXP_ID);
    set_word(1, 0, 3, 0, EXP_TS);
    pulse_start;
    cyc = 0;
    while (cyc < 40 && !(avm_read === 1'b1 && avm_address === 1'b1)) begin
      step(1);
      cyc++;
    end
    total++; if (cyc >= 40) begin bad++; $display("FAIL rm_ts_req got none want TS request within 40 cycles"); end
    step(1);
    total++; if (avm_read !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rm_wait_ts got read=%0b busy=%0b want 0/1", avm_read, busy); end
    reset = 1'b1;
    stale_inject = 1'b1;
    #1;
    total++; if (avm_read !== 1'b0 || busy !== 1'b0 || id_value !== 32'h0) begin bad++; $display("FAIL rm_abort got read=%0b busy=%0b id=%h want 0/0/0", avm_read, busy, id_value); end
    step(2);
    reset = 1'b0;
    step(1);
    stale_inject = 1'b0;
    wait_done(100, cyc, ok);
    total++; if (!ok || pass !== 1'b1) begin bad++; $display("FAIL rm_pass got done=%0b pass=%0b want 1/1", ok, pass); end
    total++; if (id_value !== EXP_ID || timestamp_value !== EXP_TS) begin bad++; $display("FAIL rm_values got=%h/%h want=%h/%h", id_value, timestamp_value, EXP_ID, EXP_TS); end
    m_id = EXP_ID;
    m_ts = EXP_TS;
  endtask

  task automatic test_random;
    int st[2], lt[2], fl[2], a0, a1, cyc, ea0, ea1;
    logic [31:0] dt[2];
    bit ok, id_ok, ts_ok, e_to, e_idm, e_tsm, e_pass;
    for (int n = 0; n < 25; n++) begin
      for (int w = 0; w < 2; w++) begin
        st[w] = ($urandom_range(0, 7) == 0) ? 200 : int'($urandom_range(0, 5));
        lt[w] = (st[w] < T) ? int'($urandom_range(0, T - 1 - st[w])) : 0;
        fl[w] = int'($urandom_range(0, 3));
        dt[w] = ($urandom_range(0, 1) == 0) ? ((w == 0) ? EXP_ID : EXP_TS) : $urandom;
        set_word(w, st[w], lt[w], fl[w], dt[w]);
      end
      id_ok = model_ok(st[0], lt[0], fl[0]);
      ts_ok = id_ok && model_ok(st[1], lt[1], fl[1]);
      ea0   = model_accepts(st[0], fl[0]);
      ea1   = id_ok ? model_accepts(st[1], fl[1]) : 0;
      if (id_ok) m_id = dt[0];
      if (ts_ok) m_ts = dt[1];
      e_to   = !ts_ok;
      e_idm  = ts_ok && (m_id != EXP_ID);
      e_tsm  = ts_ok && (m_ts != EXP_TS);
      e_pass = ts_ok && !e_idm && !e_tsm;
      a0 = acc_tot[0];
      a1 = acc_tot[1];
      pulse_start;
      wait_done(300, cyc, ok);
      total++; if (!ok) begin bad++; $display("FAIL rnd%0d_done got=0 want=1", n); end
      total++; if ({timeout_err, id_mismatch, ts_mismatch, pass} !== {e_to, e_idm, e_tsm, e_pass}) begin bad++; $display("FAIL rnd%0d_flags got to/idm/tsm/pass=%b want=%b", n, {timeout_err, id_mismatch, ts_mismatch, pass}, {e_to, e_idm, e_tsm, e_pass}); end
      total++; if (id_value !== m_id || timestamp_value !== m_ts) begin bad++; $display("FAIL rnd%0d_values got=%h/%h want=%h/%h", n, id_value, timestamp_value, m_id, m_ts); end
      total++; if (acc_tot[0] - a0 != ea0 || acc_tot[1] - a1 != ea1) begin bad++; $display("FAIL rnd%0d_accepts got=%0d/%0d want=%0d/%0d", n, acc_tot[0] - a0, acc_tot[1] - a1, ea0, ea1); end
      step(int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset;
    test_zero_wait;
    test_stall;
    test_ts_mismatch;
    test_busy_start;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
